// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes and FSM state type for the 32:1 mux arbiter
package mux_arb_pkg;
    localparam int NREQ   = 32;
    localparam int ADDR_W = 5;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick32.sv
// rr_pick32: combinational round-robin picker, first set request at ptr, ptr+1, ... wrapping
module rr_pick32
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]   req,
    input  logic [ADDR_W-1:0] ptr,
    input  logic              excl_en,
    input  logic [ADDR_W-1:0] excl,
    output logic              found,
    output logic [ADDR_W-1:0] index
);
    logic [NREQ-1:0]   masked;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    assign masked = req & ~({{(NREQ-1){1'b0}}, excl_en} << excl);
    assign dbl    = {masked, masked} >> ptr;
    assign rot    = dbl[NREQ-1:0];
    // lowest set bit of the rotated vector wins; offset back by ptr modulo 32
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                index = ptr + ADDR_W'(i);
            end
        end
    end
endmodule

// File: rtl/mux_arbiter32.sv
// mux_arbiter32: round-robin owner arbiter for a shared 32:1 mux; MUX_ARB_TIMEOUT_EN enables hold timeout
module mux_arbiter32
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   grant,
    output logic [ADDR_W-1:0] address,
    output logic              valid
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx, addr_nx, pick_idx;
    logic [NREQ-1:0]   grant_nx;
    logic              valid_nx, found, released, issue, drop, expired;

    rr_pick32 u_pick (
        .req     (req),
        .ptr     (ptr),
        .excl_en (state == BUSY),
        .excl    (address),
        .found   (found),
        .index   (pick_idx)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int              CW   = $clog2(HOLD_MAX) + 1;
    localparam logic [CW-1:0]   CMAX = CW'(HOLD_MAX - 1);
    logic [CW-1:0] cnt, cnt_nx;
    assign expired = state == BUSY && cnt == CMAX;
    // hold counter: cleared on each new grant, counts owner cycles and saturates
    always_comb begin
        cnt_nx = issue ? '0 : (state == BUSY && cnt != CMAX) ? cnt + 1'b1 : cnt;
    end
    // hold counter register
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nx;
    end
`else
    assign expired = 1'b0;
`endif

    // next owner: pick on release (or from IDLE) and on expired hold; fall to IDLE when nobody asks
    always_comb begin
        released = state == IDLE || !req[address];
        issue    = (released || expired) && found;
        drop     = released && !found;
        state_nx = issue ? BUSY : drop ? IDLE : state;
        grant_nx = issue ? NREQ'(1) << pick_idx : drop ? '0 : grant;
        valid_nx = issue || (!drop && valid);
        addr_nx  = issue ? pick_idx : address;
        ptr_nx   = issue ? pick_idx + ADDR_W'(1) : ptr;
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            address <= '0;
            valid   <= 1'b0;
            ptr     <= '0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            address <= addr_nx;
            valid   <= valid_nx;
            ptr     <= ptr_nx;
        end
    end
endmodule
